seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector; successor to the fixed 3-bit detector.
//  - Pattern length is a parameter; the pattern is runtime-loadable.
//  - Selectable overlapping/non-overlapping detection, saturating match counter.
//  - Sits after a serial bit source; match drives IRQ/status logic.

---
 rtl/seq_detector_param.sv | 159 +++++++++++++++
 tb/tb_seq_detector_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//   Parametrised serial bit-pattern detector with a runtime-loadable pattern.
//   Each accepted bit shifts into a history register. A hit is reported when
//   the last PAT_LEN accepted bits equal the pattern. With overlap=0, a hit
//   restarts the fill count so that the next match needs PAT_LEN fresh bits.
//   Hits are counted in a saturating counter.
//
// Optional feature (compile-time macro SEQDET_MASK_EN):
//   When defined, a care mask is loaded with the pattern. Bit positions whose
//   mask bit is 0 are don't-care in the compare. When undefined, the mask_in
//   port and the mask register do not exist, and every bit is compared.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous active-low reset
//   en         in   1        1 = run; 0 = hold history/fill/state/counter
//   x_valid    in   1        x carries a valid serial bit this cycle
//   x          in   1        serial data bit
//   overlap    in   1        1 = overlapping matches allowed (per accepted bit)
//   pat_load   in   1        load pat_in (and mask_in) and restart the search
//   pat_in     in   PAT_LEN  new pattern, MSB = first bit received
//   mask_in    in   PAT_LEN  care mask, 1 = compare (SEQDET_MASK_EN only)
//   cnt_clr    in   1        synchronous clear of match_cnt (wins over a hit)
//   match      out  1        one-cycle pulse, 1 cycle after the completing bit
//   match_cnt  out  CNT_W    saturating match count
//   armed      out  1        FSM state: 1 = HUNT (history holds PAT_LEN bits)
//
// Bit handshake: a bit is consumed on a rising edge when
//   en & x_valid & ~pat_load. The source has no ready back-pressure; a bit that
//   is offered in any other cycle is dropped.
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 PAT_LEN   = 3,
    parameter logic [PAT_LEN-1:0] PAT_RESET = 3'b011,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               x_valid,
    input  logic               x,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_LEN-1:0] mask_in,
`endif
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam int             FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HUNT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAT_LEN-1:0] mask_eff;

`ifdef SEQDET_MASK_EN
    logic [PAT_LEN-1:0] mask_q, mask_d;
    assign mask_eff = mask_q;
`else
    assign mask_eff = '1;
`endif

    logic               accept;
    logic               hit;
    logic [PAT_LEN-1:0] hist_next;
    logic [FW-1:0]      fill_next;

    // pat_load takes the cycle, so a concurrent serial bit is discarded.
    assign accept = en & x_valid & ~pat_load;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;
        hit       = 1'b0;
        hist_next = {hist_q[PAT_LEN-2:0], x};
        fill_next = (fill_q == FULL) ? FULL : fill_q + FW'(1);
`ifdef SEQDET_MASK_EN
        mask_d    = mask_q;
`endif

        if (pat_load) begin
            pat_d   = pat_in;
`ifdef SEQDET_MASK_EN
            mask_d  = mask_in;
`endif
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else if (accept) begin
            // The compare looks at the history including the bit arriving now,
            // so a hit on the completing bit in FILL is reported as well.
            hit    = (((hist_next ^ pat_q) & mask_eff) == '0) && (fill_next == FULL);
            hist_d = hist_next;
            if (hit && !overlap) begin
                fill_d  = '0;
                state_d = ST_FILL;
            end else begin
                fill_d  = fill_next;
                state_d = (fill_next == FULL) ? ST_HUNT : ST_FILL;
            end
        end

        match_d = hit;

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILL;
            pat_q   <= PAT_RESET;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQDET_MASK_EN
            mask_q  <= '1;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
`ifdef SEQDET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign armed     = (state_q == ST_HUNT);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_LEN=3, pattern 011, CNT_W=2).
// A queue-based model holds the last accepted bits since the last restart.
// It is compared against the DUT on every falling edge. Literal checks
// after each scenario pin the model to hand-computed results.
module tb_seq_detector_param;

  localparam int PAT_LEN = 3;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               en = 1'b1;
  logic               x_valid = 1'b0;
  logic               x = 1'b0;
  logic               overlap = 1'b1;
  logic               pat_load = 1'b0;
  logic [PAT_LEN-1:0] pat_in = '0;
  logic [PAT_LEN-1:0] mask_in = '1;
  logic               cnt_clr = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  seq_detector_param #(
    .PAT_LEN  (PAT_LEN),
    .PAT_RESET(3'b011),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .x_valid  (x_valid),
    .x        (x),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
`ifdef SEQDET_MASK_EN
    .mask_in  (mask_in),
`endif
    .cnt_clr  (cnt_clr),
    .match    (match),
    .match_cnt(match_cnt),
    .armed    (armed)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic               mq[$];
  logic [PAT_LEN-1:0] m_pat;
  logic [PAT_LEN-1:0] m_mask;
  logic               exp_match;
  int                 exp_cnt;

  always @(posedge clk or negedge reset_n) begin
    logic m_hit;
    if (!reset_n) begin
      mq.delete();
      m_pat     = 3'b011;
      m_mask    = '1;
      exp_match = 1'b0;
      exp_cnt   = 0;
    end else begin
      m_hit = 1'b0;
      if (pat_load) begin
        m_pat = pat_in;
`ifdef SEQDET_MASK_EN
        m_mask = mask_in;
`endif
        mq.delete();
      end else if (en && x_valid) begin
        mq.push_back(x);
        if (mq.size() > PAT_LEN) void'(mq.pop_front());
        if (mq.size() == PAT_LEN) begin
          m_hit = 1'b1;
          // mq[0] is the oldest bit, which lines up with the pattern MSB
          for (int i = 0; i < PAT_LEN; i++)
            if (m_mask[PAT_LEN-1-i] && (mq[i] != m_pat[PAT_LEN-1-i])) m_hit = 1'b0;
        end
        if (m_hit && !overlap) mq.delete();
      end
      exp_match = m_hit;
      if (cnt_clr) exp_cnt = 0;
      else if (m_hit && exp_cnt < CNT_MAX) exp_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("match", int'(match), int'(exp_match));
    check("match_cnt", int'(match_cnt), exp_cnt);
    check("armed", int'(armed), int'(mq.size() == PAT_LEN));
    if (match === 1'b1) pulse_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic bit_in(input logic b);
    @(negedge clk);
    pat_load = 1'b0; cnt_clr = 1'b0;
    x_valid = 1'b1; x = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pat_load = 1'b0; cnt_clr = 1'b0; x_valid = 1'b0;
    end
  endtask

  task automatic load_pat(input logic [PAT_LEN-1:0] p, input logic [PAT_LEN-1:0] m);
    @(negedge clk);
    cnt_clr = 1'b0; x_valid = 1'b0;
    pat_load = 1'b1; pat_in = p; mask_in = m;
  endtask

  task automatic clr_cnt();
    @(negedge clk);
    pat_load = 1'b0; x_valid = 1'b0; cnt_clr = 1'b1;
  endtask

  task automatic bits3(input logic [2:0] v);
    bit_in(v[2]); bit_in(v[1]); bit_in(v[0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    idle(2);
    #1;
    check("reset_cnt", int'(match_cnt), 0);
    check("reset_armed", int'(armed), 0);
    @(negedge clk); #2 reset_n = 1'b1;

    // 1: pattern 011 overlapping, stream 0,1,1,1,0,1,1
    overlap = 1'b1;
    p0 = pulse_cnt;
    bit_in(0); bit_in(1); idle(1); #1;
    check("t1_armed_before", int'(armed), 0);
    bit_in(1); idle(1); #1;
    check("t1_match_bit3", int'(match), 1);
    check("t1_armed_bit3", int'(armed), 1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(1); idle(1); #1;
    check("t1_pulses", pulse_cnt - p0, 2);
    check("t1_cnt", int'(match_cnt), 2);

    // 2: pattern 101, overlap then non-overlap
    clr_cnt(); load_pat(3'b101, 3'b111);
    p0 = pulse_cnt;
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); idle(1); #1;
    check("t2_ov_pulses", pulse_cnt - p0, 2);
    check("t2_ov_cnt", int'(match_cnt), 2);
    clr_cnt(); load_pat(3'b101, 3'b111);
    overlap = 1'b0;
    p0 = pulse_cnt;
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); idle(1); #1;
    check("t2_nov_pulses", pulse_cnt - p0, 1);
    check("t2_nov_cnt", int'(match_cnt), 1);
    check("t2_nov_armed", int'(armed), 0);

    // 3: saturation with CNT_W=2, then cnt_clr on a hit cycle
    clr_cnt(); load_pat(3'b011, 3'b111);
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) bits3(3'b011);
    idle(1); #1;
    check("t3_pulses", pulse_cnt - p0, 5);
    check("t3_sat_cnt", int'(match_cnt), 3);
    bit_in(0); bit_in(1); bit_in(1); cnt_clr = 1'b1;
    idle(1); #1;
    check("t3_clr_match", int'(match), 1);
    check("t3_clr_cnt", int'(match_cnt), 0);

    // 4: reset mid-pattern drops partial history
    overlap = 1'b1;
    bit_in(0); bit_in(1);
    @(negedge clk); x_valid = 1'b0; #2 reset_n = 1'b0;
    @(negedge clk); #2 reset_n = 1'b1;
    p0 = pulse_cnt;
    bit_in(1); idle(1); #1;
    check("t4_no_match", pulse_cnt - p0, 0);
    bit_in(0); bit_in(1); bit_in(1); idle(1); #1;
    check("t4_match", int'(match), 1);
    check("t4_pulses", pulse_cnt - p0, 1);

    // 5: pat_load drops a concurrent bit; en=0 holds everything
    load_pat(3'b011, 3'b111); x_valid = 1'b1; x = 1'b1;
    bit_in(0); bit_in(1); idle(1); #1;
    check("t5_armed_after_load", int'(armed), 0);
    p0 = pulse_cnt;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); x_valid = i[0]; x = 1'b1;
    end
    idle(1); #1;
    check("t5_en0_pulses", pulse_cnt - p0, 0);
    check("t5_en0_armed", int'(armed), 0);
    en = 1'b1;
    bit_in(1); idle(1); #1;
    check("t5_resume_match", int'(match), 1);
    check("t5_resume_armed", int'(armed), 1);

    // 6: mask 101 makes the middle bit don't-care when the mask is built in
    load_pat(3'b101, 3'b101);
    p0 = pulse_cnt;
    bits3(3'b101); idle(1); #1;
    check("t6_101", pulse_cnt - p0, 1);
    load_pat(3'b101, 3'b101);
    p0 = pulse_cnt;
    bits3(3'b111); idle(1); #1;
`ifdef SEQDET_MASK_EN
    check("t6_111_masked", pulse_cnt - p0, 1);
`else
    check("t6_111_exact", pulse_cnt - p0, 0);
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
